pwm_bank_ctrl: RTL
==================

# pwm_bank_ctrl

Parametrised multi-channel PWM generator and register bank, the next generation of the team's fixed 16-channel SPI-configured PWM peripheral. It takes single-cycle register writes from the SPI front end and drives CHANNELS pad outputs. Each channel can be off, static high or PWM, with optional inversion. It adds a clock prescaler, a run/stop control, duty-cycle double-buffering with glitch-free updates at the period boundary, and a period-start strobe.

## Interface
- CHANNELS, 16, number of outputs; multiple of 8, range 8..64
- RES, 8, PWM counter/duty resolution in bits; range 2..8
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write strobe, one clk cycle per write
- wr_addr  input  7  register address
- wr_data  input  8  write data
- out  output  CHANNELS  channel outputs, registered
- period_start  output  1  one-cycle pulse at each PWM period wrap

## Operation
Register map. Writes with wr_en=0, or to unlisted addresses, are ignored. There is no read path.
- 0x00+k, k < CHANNELS/8: oe byte k. Bit j is the output enable of channel 8k+j.
- 0x10+k: pe byte k. Bit j selects PWM mode for channel 8k+j.
- 0x20: presc[7:0]. The counter advances once every presc+1 clk cycles.
- 0x21: ctrl. Bit0 is run, bit1 is invert; bits 7:2 are ignored.
- 0x40+i, i < CHANNELS: shadow duty of channel i, taken from wr_data[RES-1:0]. Addresses with i ≥ CHANNELS are ignored.

Datapath:
- Prescaler counter pcnt (8 bits). tick = run && pcnt ≥ presc. On tick, pcnt is cleared to 0; otherwise, when run=1, pcnt is incremented.
- PWM counter cnt (RES bits) counts 0..MAX, where MAX = 2^RES − 2. A period is 2^RES − 1 ticks.
  - On a tick with cnt==MAX: cnt wraps to 0, every active duty is loaded from its shadow, and period_start is set to 1 on the same edge.
  - On any other tick: cnt increments.
- run=0: pcnt and cnt are held at 0 and period_start stays 0. Each shadow is copied to its active register on every cycle, so writes take effect immediately.
- Channel function, registered into out[i]:
  - oe=0: out[i] = 0.
  - oe=1, pe=0: out[i] = 1 ^ invert.
  - oe=1, pe=1: out[i] = (cnt < active_duty[i]) ^ invert.
- Duty boundary values:
  - duty 0: never high.
  - duty 2^RES − 1: always high.
  - duty d: high for d ticks of each period, starting at cnt=0.

## Timing
- Reset values:
  - oe, pe, presc, shadow and active duties, pcnt, cnt: 0
  - run = 1, invert = 0
  - out = 0, period_start = 0
- Write latency: a register write captured at edge E changes out at edge E+1 (oe, pe, invert), subject to the double-buffering below for duty.
- out lags cnt by one clk: out at edge E+1 reflects cnt and registers as they stood after edge E.
- period_start is high for exactly one clk, in the cycle after the wrap edge.
- Double-buffering:
  - While run=1, a duty write never alters the current period.
  - If a write lands on the same edge as a wrap, the active register takes the pre-write shadow, and the new value becomes active at the following wrap.
- Writing presc below the current pcnt causes a tick on the next cycle; there is no wrap-around of pcnt.
- Clearing run mid-period: cnt is 0 on the next edge, and outputs follow the cnt=0 compare.
- Setting run: the first tick occurs after presc+1 cycles.
- Asserting rst_n low at any time forces all reset values immediately, independent of clk.

## Test plan
- Reset and static mode, with defaults: all out=0 after reset. Write oe0=0xFF, pe0=0x00: out[7:0]=0xFF one cycle after the write. Write ctrl=0x03 (run plus invert): out[7:0]=0x00.
- Duty sweep (RES=8, presc=0, oe0=pe0=0x01):
  - duty 128: out[0] high for 128 of every 255 cycles.
  - duty 0: never high.
  - duty 255: always high.
  - period_start pulses every 255 cycles.
- Double-buffering: with duty 200 active, write 50 at cnt=10. The current period still shows 200 high cycles, and the next period shows 50. Repeat with the write landing on the wrap edge: the new duty appears one period later.
- Prescaler: presc=3, duty 64 gives a period of 1020 cycles and a high time of 256 cycles. Writing presc=0 while pcnt=2 produces a tick on the next cycle.
- Address decode (CHANNELS=16): writes to 0x02, 0x12, 0x50 and 0x7F leave all outputs and registers unchanged. Writes with wr_en=0 are ignored.
- Run/stop and reset mid-operation:
  - run=0 holds cnt at 0, and a duty write is visible on the next out update.
  - Pulsing rst_n low mid-period clears out and period_start asynchronously, with registers back at their reset values.

Source files
------------

// File: rtl/pwm_bank_ctrl.sv
// Multi-channel PWM generator with a write-only register bank, clock prescaler,
// run/stop control and duty double-buffering that updates at the period wrap.
module pwm_bank_ctrl #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned RES      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [6:0]          wr_addr,
    input  logic [7:0]          wr_data,
    output logic [CHANNELS-1:0] out,
    output logic                period_start
);

    localparam int unsigned NBYTES  = CHANNELS / 8;
    localparam int unsigned MAX_INT = (1 << RES) - 2;
    localparam logic [RES-1:0] CNT_MAX = RES'(MAX_INT);

    logic [CHANNELS-1:0]          oe_q, oe_d;
    logic [CHANNELS-1:0]          pe_q, pe_d;
    logic [7:0]                   presc_q, presc_d;
    logic                         run_q, run_d;
    logic                         inv_q, inv_d;
    logic [CHANNELS-1:0][RES-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0][RES-1:0] active_q, active_d;
    logic [7:0]                   pcnt_q, pcnt_d;
    logic [RES-1:0]               cnt_q, cnt_d;
    logic [CHANNELS-1:0]          out_q, out_d;
    logic                         ps_q, ps_d;
    logic                         tick;
    logic                         wrap;

    // Register write decode; unmapped addresses fall through untouched
    always_comb begin
        oe_d     = oe_q;
        pe_d     = pe_q;
        presc_d  = presc_q;
        run_d    = run_q;
        inv_d    = inv_q;
        shadow_d = shadow_q;
        if (wr_en) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wr_addr == 7'(k))      oe_d[8*k +: 8] = wr_data;
                if (wr_addr == 7'(16 + k)) pe_d[8*k +: 8] = wr_data;
            end
            if (wr_addr == 7'h20) presc_d = wr_data;
            if (wr_addr == 7'h21) begin
                run_d = wr_data[0];
                inv_d = wr_data[1];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == 7'(64 + i)) shadow_d[i] = wr_data[RES-1:0];
            end
        end
    end

    // Prescaler, period counter and duty transfer; stopped state forwards writes at once
    always_comb begin
        tick   = run_q && (pcnt_q >= presc_q);
        wrap   = tick && (cnt_q == CNT_MAX);
        pcnt_d = (!run_q || tick) ? 8'd0 : pcnt_q + 8'd1;
        cnt_d  = cnt_q;
        if (!run_q || wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + RES'(1);
        end
        ps_d     = wrap;
        active_d = active_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!run_q) begin
                active_d[i] = shadow_d[i];
            end else if (wrap) begin
                active_d[i] = shadow_q[i];
            end
        end
    end

    // Per-channel output function from the current counter and registers
    always_comb begin
        out_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            out_d[i] = oe_q[i] & ((pe_q[i] ? (cnt_q < active_q[i]) : 1'b1) ^ inv_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_q     <= '0;
            pe_q     <= '0;
            presc_q  <= '0;
            run_q    <= 1'b1;
            inv_q    <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            pcnt_q   <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ps_q     <= 1'b0;
        end else begin
            oe_q     <= oe_d;
            pe_q     <= pe_d;
            presc_q  <= presc_d;
            run_q    <= run_d;
            inv_q    <= inv_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pcnt_q   <= pcnt_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ps_q     <= ps_d;
        end
    end

    assign out          = out_q;
    assign period_start = ps_q;

endmodule
